// File: rtl/msrv32_irq_ctrl.sv
// msrv32_irq_ctrl: machine interrupt controller, synchronises eirq/tirq/sirq, applies enables,
// picks one cause by MEI > MSI > MTI and runs a request/ack/mret handshake with the trap unit.
module msrv32_irq_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int EIRQ_EDGE   = 0
) (
  input  logic       ms_riscv32_mp_clk_in,
  input  logic       ms_riscv32_mp_rst_in,
  input  logic       ms_riscv32_mp_eirq_in,
  input  logic       ms_riscv32_mp_tirq_in,
  input  logic       ms_riscv32_mp_sirq_in,
  input  logic       mstatus_mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       trap_taken_in,
  input  logic       mret_in,
  output logic       irq_req_out,
  output logic [3:0] irq_cause_out,
  output logic [2:0] mip_out,
  output logic       irq_busy_out
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;
  logic [SYNC_STAGES-1:0] sync_e, sync_t, sync_s;
  logic       e_prev, meip_q;
  logic [1:0] state;
  logic [3:0] cause_q;
  logic [2:0] mip_q, pend, elig;
  logic [3:0] win;
  logic       e_sync, e_rise, clr, locked_elig;
  assign e_sync      = sync_e[SYNC_STAGES-1];
  assign e_rise      = (EIRQ_EDGE != 0) ? (e_sync & ~e_prev) : 1'b0;
  // In edge mode the rising edge itself counts as pending so latency matches level mode
  assign pend        = {(EIRQ_EDGE != 0) ? (meip_q | e_rise) : e_sync,
                        sync_t[SYNC_STAGES-1], sync_s[SYNC_STAGES-1]};
  assign elig        = pend & {meie_in, mtie_in, msie_in} & {3{mstatus_mie_in}};
  assign win         = elig[2] ? 4'd11 : elig[0] ? 4'd3 : 4'd7;
  assign locked_elig = (cause_q == 4'd11) ? elig[2] : (cause_q == 4'd3) ? elig[0] : elig[1];
  assign clr         = (state == REQ) && trap_taken_in && (cause_q == 4'd11);
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      sync_e  <= '0;
      sync_t  <= '0;
      sync_s  <= '0;
      e_prev  <= 1'b0;
      meip_q  <= 1'b0;
      mip_q   <= 3'b000;
      state   <= IDLE;
      cause_q <= 4'd0;
    end else begin
      sync_e  <= {sync_e[SYNC_STAGES-2:0], ms_riscv32_mp_eirq_in};
      sync_t  <= {sync_t[SYNC_STAGES-2:0], ms_riscv32_mp_tirq_in};
      sync_s  <= {sync_s[SYNC_STAGES-2:0], ms_riscv32_mp_sirq_in};
      e_prev  <= e_sync;
      meip_q  <= (EIRQ_EDGE != 0) && (e_rise || (meip_q && !clr));
      mip_q   <= pend;
      case (state)
        IDLE: if (elig != 3'b000) begin
          state   <= REQ;
          cause_q <= win;
        end
        REQ: if (trap_taken_in) begin
          state <= SERVICE;
        end else if (!locked_elig) begin
          state   <= IDLE;
          cause_q <= 4'd0;
        end
        SERVICE: if (mret_in) begin
          state   <= IDLE;
          cause_q <= 4'd0;
        end
        default: begin
          state   <= IDLE;
          cause_q <= 4'd0;
        end
      endcase
    end
  end
  assign irq_req_out   = state == REQ;
  assign irq_busy_out  = state == SERVICE;
  assign irq_cause_out = cause_q;
  assign mip_out       = mip_q;
endmodule

// File: tb/tb_msrv32_irq_ctrl.sv
// tb_msrv32_irq_ctrl: random stimulus on a level-mode and an edge-mode controller, scoreboarded
// against a cycle-indexed pin log and an abstract request/service model.
module tb_msrv32_irq_ctrl;
  typedef struct packed {logic req; logic busy; logic [3:0] cause; logic [2:0] mip;} exp_t;
  typedef struct packed {exp_t m1; exp_t m0;} pair_t;
  localparam int NCYC = 3000;
  localparam int DEP0 = 2;
  localparam int DEP1 = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0, eirq = 1'b0, tirq = 1'b0, sirq = 1'b0;
  logic mie = 1'b0, meie = 1'b0, mtie = 1'b0, msie = 1'b0, ack = 1'b0, mret = 1'b0;
  logic       req_o [2];
  logic       busy_o[2];
  logic [3:0] cause_o[2];
  logic [2:0] mip_o [2];
  msrv32_irq_ctrl #(.SYNC_STAGES(DEP0), .EIRQ_EDGE(0)) dut_lvl (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .ms_riscv32_mp_eirq_in(eirq), .ms_riscv32_mp_tirq_in(tirq), .ms_riscv32_mp_sirq_in(sirq),
    .mstatus_mie_in(mie), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .trap_taken_in(ack), .mret_in(mret),
    .irq_req_out(req_o[0]), .irq_cause_out(cause_o[0]), .mip_out(mip_o[0]), .irq_busy_out(busy_o[0]));
  msrv32_irq_ctrl #(.SYNC_STAGES(DEP1), .EIRQ_EDGE(1)) dut_edg (
    .ms_riscv32_mp_clk_in(clk), .ms_riscv32_mp_rst_in(rst_n),
    .ms_riscv32_mp_eirq_in(eirq), .ms_riscv32_mp_tirq_in(tirq), .ms_riscv32_mp_sirq_in(sirq),
    .mstatus_mie_in(mie), .meie_in(meie), .mtie_in(mtie), .msie_in(msie),
    .trap_taken_in(ack), .mret_in(mret),
    .irq_req_out(req_o[1]), .irq_cause_out(cause_o[1]), .mip_out(mip_o[1]), .irq_busy_out(busy_o[1]));
  logic [2:0] pin_log[0:NCYC+8];
  int         n = 0, last_rst = 0, rst_hold = 3;
  int         st[2];
  logic [3:0] mc[2];
  logic [2:0] mmip[2];
  logic       meip[2];
  pair_t      sbq[$];
  pair_t      cur;
  int         total = 0, bad = 0;
  // Pin value seen at the synchroniser output after edge 'at'; samples up to the last reset edge are lost
  function automatic logic [2:0] synced(int m, int at);
    int idx;
    idx = at - ((m == 0) ? DEP0 : DEP1) + 1;
    return (idx >= 1 && idx > last_rst) ? pin_log[idx] : 3'b000;
  endfunction
  function automatic exp_t outs(int m);
    return {st[m] == 1, st[m] == 2, mc[m], mmip[m]};
  endfunction
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      cur = sbq.pop_front();
      total++;
      if ({req_o[0], busy_o[0], cause_o[0], mip_o[0]} !== cur.m0) begin
        bad++;
        $display("FAIL level t=%0t got req=%b busy=%b cause=%0d mip=%b want req=%b busy=%b cause=%0d mip=%b",
                 $time, req_o[0], busy_o[0], cause_o[0], mip_o[0], cur.m0.req, cur.m0.busy, cur.m0.cause, cur.m0.mip);
      end
      total++;
      if ({req_o[1], busy_o[1], cause_o[1], mip_o[1]} !== cur.m1) begin
        bad++;
        $display("FAIL edge t=%0t got req=%b busy=%b cause=%0d mip=%b want req=%b busy=%b cause=%0d mip=%b",
                 $time, req_o[1], busy_o[1], cause_o[1], mip_o[1], cur.m1.req, cur.m1.busy, cur.m1.cause, cur.m1.mip);
      end
    end
  end
  initial begin
    for (int i = 0; i <= NCYC + 8; i++) pin_log[i] = 3'b000;
    for (int m = 0; m < 2; m++) begin
      st[m] = 0; mc[m] = 4'd0; mmip[m] = 3'b000; meip[m] = 1'b0;
    end
    repeat (2) @(posedge clk);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      if (rst_hold > 0) begin
        rst_n = 1'b0;
        rst_hold--;
      end else if ($urandom_range(199) == 0) begin
        rst_n = 1'b0;
        rst_hold = $urandom_range(2);
      end else rst_n = 1'b1;
      if ($urandom_range(3) == 0) eirq = ~eirq;
      if ($urandom_range(7) == 0) tirq = ~tirq;
      if ($urandom_range(7) == 0) sirq = ~sirq;
      if ($urandom_range(31) == 0) mie = ~mie;
      if ($urandom_range(15) == 0) meie = ~meie;
      if ($urandom_range(15) == 0) mtie = ~mtie;
      if ($urandom_range(15) == 0) msie = ~msie;
      if (c < 20) begin mie = 1'b1; meie = 1'b1; mtie = 1'b1; msie = 1'b1; end
      ack  = $urandom_range(3) == 0;
      mret = $urandom_range(4) == 0;
      if (!rst_n) begin
        last_rst = n + 1;
        for (int m = 0; m < 2; m++) begin
          st[m] = 0; mc[m] = 4'd0; mmip[m] = 3'b000; meip[m] = 1'b0;
        end
      end
      sbq.push_back({outs(1), outs(0)});
      if (rst_n) begin
        for (int m = 0; m < 2; m++) begin
          logic [2:0] s, sp, p, el;
          logic       rise;
          int         li;
          s    = synced(m, n);
          sp   = synced(m, n - 1);
          rise = (m == 1) && s[2] && !sp[2];
          p    = {(m == 1) ? (meip[m] | rise) : s[2], s[1:0]};
          el   = p & {meie, mtie, msie} & {3{mie}};
          li   = (mc[m] == 4'd11) ? 2 : (mc[m] == 4'd3) ? 0 : 1;
          if (m == 1) meip[m] = rise | (meip[m] & !(st[m] == 1 && ack && mc[m] == 4'd11));
          mmip[m] = p;
          if (st[m] == 0) begin
            if (el != 3'b000) begin
              st[m] = 1;
              mc[m] = el[2] ? 4'd11 : el[0] ? 4'd3 : 4'd7;
            end
          end else if (st[m] == 1) begin
            if (ack) st[m] = 2;
            else if (!el[li]) begin st[m] = 0; mc[m] = 4'd0; end
          end else if (mret) begin
            st[m] = 0; mc[m] = 4'd0;
          end
        end
      end
      n++;
      pin_log[n] = {eirq, tirq, sirq};
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
